// File: rtl/mar_burst.sv
// Memory address register with a strobed source mux, inc/dec and a counted
// auto-increment burst mode. All outputs come straight from flops.
module mar_burst #(
  parameter int ADDR_W = 4,
  parameter int NSRC   = 2,
  localparam int SEL_W = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [NSRC*ADDR_W-1:0]   src,
  input  logic [SEL_W-1:0]         src_sel,
  input  logic                     g,
  input  logic                     g1,
  input  logic                     g2,
  input  logic                     inc,
  input  logic                     dec,
  input  logic                     burst_start,
  input  logic [ADDR_W-1:0]        burst_len,
  output logic [ADDR_W-1:0]        MAR_out,
  output logic                     burst_busy,
  output logic                     burst_done,
  output logic                     wrap
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [ADDR_W-1:0] mux_out;
  logic              done_nxt, wrap_nxt;
  logic              load;

  assign load = ~g1 & ~g2;

  // Select values with no matching source fall through to zero, as does a high strobe.
  always_comb begin
    mux_out = '0;
    if (!g) begin
      for (int k = 0; k < NSRC; k++) begin
        if (src_sel == SEL_W'(k)) mux_out = src[k*ADDR_W +: ADDR_W];
      end
    end
  end

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    addr_nxt  = MAR_out;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    wrap_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          addr_nxt = mux_out;
        end else if (burst_start) begin
          if (burst_len == '0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = BURST;
            cnt_nxt   = burst_len - 1'b1;
          end
        end else if (inc) begin
          addr_nxt = MAR_out + 1'b1;
          wrap_nxt = &MAR_out;
        end else if (dec) begin
          addr_nxt = MAR_out - 1'b1;
          wrap_nxt = ~|MAR_out;
        end
      end
      BURST: begin
        // A load aborts the burst silently; cnt reaching zero ends it with a done pulse.
        if (load) begin
          addr_nxt  = mux_out;
          state_nxt = IDLE;
        end else if (cnt == '0) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          addr_nxt = MAR_out + 1'b1;
          cnt_nxt  = cnt - 1'b1;
          wrap_nxt = &MAR_out;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= IDLE;
      MAR_out    <= '0;
      cnt        <= '0;
      burst_done <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      state      <= state_nxt;
      MAR_out    <= addr_nxt;
      cnt        <= cnt_nxt;
      burst_done <= done_nxt;
      wrap       <= wrap_nxt;
    end
  end

  assign burst_busy = (state == BURST);

endmodule

// File: tb/tb_mar_burst.sv
// Bench for mar_burst: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_mar_burst;

  localparam int W    = 4;
  localparam int AMAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic [7:0]   src = '0;
  logic [0:0]   src_sel = '0;
  logic         g = 1'b1, g1 = 1'b1, g2 = 1'b1;
  logic         inc = 1'b0, dec = 1'b0, burst_start = 1'b0;
  logic [W-1:0] burst_len = '0;
  logic [W-1:0] mar;
  logic         busy, done, wrap;

  // Single-source instance for the out-of-range select case.
  logic [3:0]   src1 = '0;
  logic [0:0]   sel1 = '0;
  logic         a_g = 1'b1, a_g1 = 1'b1, a_g2 = 1'b1;
  logic         a_zero = 1'b0;
  logic [W-1:0] a_len = '0;
  logic [W-1:0] mar1;
  logic         busy1, done1, wrap1;

  int n_cmp = 0;
  int n_fail = 0;

  mar_burst #(.ADDR_W(W), .NSRC(2)) u_dut (
    .clk(clk), .clr(clr), .src(src), .src_sel(src_sel), .g(g), .g1(g1), .g2(g2),
    .inc(inc), .dec(dec), .burst_start(burst_start), .burst_len(burst_len),
    .MAR_out(mar), .burst_busy(busy), .burst_done(done), .wrap(wrap)
  );

  mar_burst #(.ADDR_W(W), .NSRC(1)) u_dut1 (
    .clk(clk), .clr(clr), .src(src1), .src_sel(sel1), .g(a_g), .g1(a_g1), .g2(a_g2),
    .inc(a_zero), .dec(a_zero), .burst_start(a_zero), .burst_len(a_len),
    .MAR_out(mar1), .burst_busy(busy1), .burst_done(done1), .wrap(wrap1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a burst is a queue of the addresses still to be presented.
  int m_addr = 0;
  bit m_busy = 0, m_done = 0, m_wrap = 0;
  int m_q[$];

  always @(posedge clk) begin
    int mux;
    bit nd, nw;
    if (clr) begin
      m_addr = 0; m_busy = 0; m_done = 0; m_wrap = 0;
      m_q.delete();
    end else begin
      mux = g ? 0 : int'(src >> (4 * int'(src_sel))) % 16;
      nd = 0; nw = 0;
      if (m_busy) begin
        if (!g1 && !g2) begin
          m_addr = mux; m_busy = 0; m_q.delete();
        end else if (m_q.size() == 0) begin
          m_busy = 0; nd = 1;
        end else begin
          nw = (m_addr == AMAX);
          m_addr = m_q.pop_front();
        end
      end else if (!g1 && !g2) begin
        m_addr = mux;
      end else if (burst_start) begin
        if (burst_len == 0) nd = 1;
        else begin
          m_busy = 1;
          for (int k = 1; k < int'(burst_len); k++) m_q.push_back((m_addr + k) % (AMAX + 1));
        end
      end else if (inc) begin
        nw = (m_addr == AMAX);
        m_addr = (m_addr + 1) % (AMAX + 1);
      end else if (dec) begin
        nw = (m_addr == 0);
        m_addr = (m_addr + AMAX) % (AMAX + 1);
      end
      m_done = nd;
      m_wrap = nw;
    end
    #1;
    check("model MAR_out", 32'(mar), 32'(m_addr));
    check("model busy", 32'(busy), 32'(m_busy));
    check("model done", 32'(done), 32'(m_done));
    check("model wrap", 32'(wrap), 32'(m_wrap));
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    g = 1'b1; g1 = 1'b1; g2 = 1'b1; inc = 1'b0; dec = 1'b0; burst_start = 1'b0;
  endtask

  task automatic load(input logic [3:0] v);
    idle();
    src = {4'h3, v}; src_sel = 1'b0; g = 1'b0; g1 = 1'b0; g2 = 1'b0;
  endtask

  task automatic start(input logic [W-1:0] len);
    idle();
    burst_start = 1'b1; burst_len = len;
  endtask

  initial begin
    tick();
    check("reset MAR", 32'(mar), 0);
    check("reset busy/done/wrap", {busy, done, wrap}, 0);
    tick();
    clr = 1'b0;

    // Load from source 1 of {3,9}, then blocked loads and strobe-off.
    src = 8'h39; src_sel = 1'b1; g = 1'b0; g1 = 1'b0; g2 = 1'b0;
    tick(); check("load src1", 32'(mar), 32'h3);
    src_sel = 1'b0; g1 = 1'b1;
    tick(); check("g1 high holds", 32'(mar), 32'h3);
    g1 = 1'b0; g = 1'b1;
    tick(); check("g high loads zero", 32'(mar), 32'h0);

    // Wrap on inc and dec, inc-over-dec priority.
    load(4'hF); tick(); check("load F", 32'(mar), 32'hF);
    idle(); inc = 1'b1;
    tick(); check("inc wraps", {mar, wrap}, {4'h0, 1'b1});
    idle();
    tick(); check("wrap one cycle", {mar, wrap}, {4'h0, 1'b0});
    dec = 1'b1;
    tick(); check("dec wraps", {mar, wrap}, {4'hF, 1'b1});
    load(4'h5); tick();
    idle(); inc = 1'b1; dec = 1'b1;
    tick(); check("inc beats dec", {mar, wrap}, {4'h6, 1'b0});

    // Burst of 4 from D crossing zero.
    load(4'hD); tick();
    start(4);
    tick(); check("burst c0", {mar, busy, done, wrap}, {4'hD, 3'b100});
    idle();
    tick(); check("burst c1", {mar, busy, done, wrap}, {4'hE, 3'b100});
    tick(); check("burst c2", {mar, busy, done, wrap}, {4'hF, 3'b100});
    tick(); check("burst c3 wrap", {mar, busy, done, wrap}, {4'h0, 3'b101});
    tick(); check("burst done", {mar, busy, done, wrap}, {4'h0, 3'b010});
    tick(); check("done one cycle", {mar, busy, done}, {4'h0, 2'b00});

    // Zero-length burst.
    start(0);
    tick(); check("len0 done", {mar, busy, done}, {4'h0, 2'b01});
    idle();
    tick(); check("len0 done clears", {busy, done}, 0);

    // Burst of 6 from 2 aborted by a load on its third busy cycle.
    load(4'h2); tick();
    start(6);
    tick(); check("abort c0", {mar, busy}, {4'h2, 1'b1});
    idle();
    tick(); check("abort c1", {mar, busy}, {4'h3, 1'b1});
    tick(); check("abort c2", {mar, busy}, {4'h4, 1'b1});
    load(4'hA);
    tick(); check("abort load", {mar, busy, done}, {4'hA, 2'b00});
    idle();
    tick(); check("abort no done", {busy, done}, 0);

    // clr mid-burst, checked before any clock edge.
    start(5); tick(); idle(); tick();
    #2 clr = 1'b1;
    #1 check("async clr", {mar, busy, done, wrap}, 0);
    @(negedge clk) clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); check("post clr quiet", {mar, busy, done}, 0);
    end

    // Single-source instance: out-of-range select loads zero.
    src1 = 4'h7; sel1 = 1'b0; a_g = 1'b0; a_g1 = 1'b0; a_g2 = 1'b0;
    tick(); check("nsrc1 sel0", 32'(mar1), 32'h7);
    sel1 = 1'b1;
    tick(); check("nsrc1 sel out of range", 32'(mar1), 32'h0);
    a_g1 = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      clr         = ($urandom_range(0, 249) == 0);
      src         = 8'($urandom);
      src_sel     = 1'($urandom_range(0, 1));
      g           = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) {g1, g2} = 2'b00;
      else {g1, g2} = 2'($urandom_range(1, 3));
      inc         = ($urandom_range(0, 2) == 0);
      dec         = ($urandom_range(0, 2) == 0);
      burst_start = ($urandom_range(0, 3) == 0);
      burst_len   = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
    end
    @(negedge clk);
    clr = 1'b0; idle();
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
